// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// CPU side: req/wr/addr/wdata/byte_en in, rd_data/stall out, inv_i clears all lines.
// Memory side: req/wr/addr/wdata/byte_en out, rd_data/ready in. Hit/miss load counters out.
module dcache_wt #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_wr_en_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data_i,
    input  logic [3:0]            cpu_byte_en_i,
    output logic [DATA_WIDTH-1:0] cpu_rd_data_o,
    output logic                  cpu_stall_o,
    input  logic                  inv_i,
    output logic                  mem_req_o,
    output logic                  mem_wr_en_o,
    output logic [31:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    output logic [3:0]            mem_byte_en_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    input  logic                  mem_ready_i,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

    state_e                 state_q, state_d;
    logic [SETS-1:0]        valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;
    logic [TAG_W-1:0]       tag_mem [SETS];
    logic [DATA_WIDTH-1:0]  data_mem [SETS];

    logic [IDX-1:0]         idx;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic [DATA_WIDTH-1:0]  line;
    logic [DATA_WIDTH-1:0]  merged;
    logic                   ld_hit, ld_miss, fill_done, wr_done;
    logic                   unused_addr;

    assign idx  = cpu_addr_i[2 +: IDX];
    assign tag  = cpu_addr_i[31 -: TAG_W];
    assign hit  = valid_q[idx] && (tag_mem[idx] == tag);
    assign line = data_mem[idx];
    assign unused_addr = ^cpu_addr_i[1:0];

    assign ld_hit    = (state_q == IDLE) && cpu_req_i && !cpu_wr_en_i && hit;
    assign ld_miss   = (state_q == IDLE) && cpu_req_i && !cpu_wr_en_i && !hit;
    assign fill_done = (state_q == FILL) && mem_ready_i;
    assign wr_done   = (state_q == WRITE) && mem_ready_i;

    always_comb begin
        merged = line;
        for (int b = 0; b < 4; b++) begin
            if (cpu_byte_en_i[b]) merged[8*b +: 8] = cpu_wr_data_i[8*b +: 8];
        end
    end

    always_comb begin
        state_d       = state_q;
        cpu_stall_o   = 1'b0;
        cpu_rd_data_o = '0;
        mem_req_o     = 1'b0;
        mem_wr_en_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
        mem_byte_en_o = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i && cpu_wr_en_i) begin
                    cpu_stall_o = 1'b1;
                    state_d     = WRITE;
                end else if (ld_miss) begin
                    cpu_stall_o = 1'b1;
                    state_d     = FILL;
                end else if (ld_hit) begin
                    cpu_rd_data_o = line;
                end
            end
            FILL: begin
                mem_req_o     = 1'b1;
                mem_addr_o    = {cpu_addr_i[31:2], 2'b00};
                mem_byte_en_o = 4'b1111;
                cpu_stall_o   = !mem_ready_i;
                if (mem_ready_i) begin
                    cpu_rd_data_o = mem_rd_data_i;
                    state_d       = IDLE;
                end
            end
            WRITE: begin
                mem_req_o     = 1'b1;
                mem_wr_en_o   = 1'b1;
                mem_addr_o    = {cpu_addr_i[31:2], 2'b00};
                mem_wr_data_o = cpu_wr_data_i;
                mem_byte_en_o = cpu_byte_en_i;
                cpu_stall_o   = !mem_ready_i;
                if (mem_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Invalidate overrides a coincident fill so the filled line stays invalid.
    always_comb begin
        valid_d = valid_q;
        if (fill_done) valid_d[idx] = 1'b1;
        if (inv_i) valid_d = '0;
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (ld_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        if (ld_miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Arrays carry no reset; reset forces IDLE, which blocks any update.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_rd_data_i;
        end else if (wr_done && hit) begin
            data_mem[idx] <= merged;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: backing-memory model plus a
// scoreboard of expected load data, one task per scenario.
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_i, cpu_wr_en_i;
    logic [31:0] cpu_addr_i, cpu_wr_data_i;
    logic [3:0]  cpu_byte_en_i;
    logic [31:0] cpu_rd_data_o;
    logic        cpu_stall_o, inv_i;
    logic        mem_req_o, mem_wr_en_o;
    logic [31:0] mem_addr_o, mem_wr_data_o;
    logic [3:0]  mem_byte_en_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_ready_i;
    logic [31:0] hit_cnt_o, miss_cnt_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [logic [29:0]];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    dcache_wt #(.DATA_WIDTH(32), .SETS(64), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_wr_en_i(cpu_wr_en_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wr_data_i(cpu_wr_data_i),
        .cpu_byte_en_i(cpu_byte_en_i), .cpu_rd_data_o(cpu_rd_data_o),
        .cpu_stall_o(cpu_stall_o), .inv_i(inv_i),
        .mem_req_o(mem_req_o), .mem_wr_en_o(mem_wr_en_o),
        .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
        .mem_byte_en_o(mem_byte_en_o), .mem_rd_data_i(mem_rd_data_i),
        .mem_ready_i(mem_ready_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    function automatic logic [31:0] mrd(input logic [31:0] a);
        if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Drives one CPU access; memory raises ready on the lat-th mem_req cycle.
    task automatic access(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int lat, input logic inv_rdy,
                          output int cyc, output int nreq,
                          output logic [31:0] rdata, output logic mwr,
                          output logic [3:0] mbe, output logic [31:0] maddr);
        logic done;
        logic [31:0] w;
        cyc = 0; nreq = 0; rdata = '0; mwr = 1'b0; mbe = '0; maddr = '0;
        done = 1'b0;
        cpu_req_i = 1'b1; cpu_wr_en_i = wr; cpu_addr_i = addr;
        cpu_wr_data_i = wdata; cpu_byte_en_i = be;
        for (int k = 0; k < 64; k++) begin
            if (mem_req_o) begin
                nreq++;
                if (nreq == 1) begin
                    mwr = mem_wr_en_o; mbe = mem_byte_en_o; maddr = mem_addr_o;
                end
                if (nreq == lat) begin
                    mem_ready_i = 1'b1;
                    mem_rd_data_i = mrd(mem_addr_o);
                    inv_i = inv_rdy;
                end
            end
            @(negedge clk);
            cyc++;
            done = !cpu_stall_o;
            if (done) begin
                rdata = cpu_rd_data_o;
                if (mem_ready_i && mem_req_o && mem_wr_en_o) begin
                    w = mrd(mem_addr_o);
                    for (int b = 0; b < 4; b++)
                        if (mem_byte_en_o[b]) w[8*b +: 8] = mem_wr_data_o[8*b +: 8];
                    mem_model[mem_addr_o[31:2]] = w;
                end
            end
            @(posedge clk); #1;
            mem_ready_i = 1'b0; inv_i = 1'b0; mem_rd_data_i = '0;
            if (done) break;
        end
        cpu_req_i = 1'b0; cpu_wr_en_i = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout addr=%h got=stalled want=done", addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req_i = 0; cpu_wr_en_i = 0; cpu_addr_i = 0; cpu_wr_data_i = 0;
        cpu_byte_en_i = 0; inv_i = 0; mem_rd_data_i = 0; mem_ready_i = 0;
        #12;
        checks++;
        if ({cpu_stall_o, mem_req_o, mem_wr_en_o, mem_byte_en_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b want=0",
                     {cpu_stall_o, mem_req_o, mem_wr_en_o, mem_byte_en_o});
        end
        checks++;
        if ({mem_addr_o, mem_wr_data_o, cpu_rd_data_o} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data got=%h %h %h want=0",
                     mem_addr_o, mem_wr_data_o, cpu_rd_data_o);
        end
        checks++;
        if (hit_cnt_o !== 0 || miss_cnt_o !== 0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d/%0d want=0/0", hit_cnt_o, miss_cnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_cold_load();
        int cyc, nreq; logic [31:0] rd, ma; logic mw; logic [3:0] mb;
        exp_q.push_back(mrd(32'h100));
        access(0, 32'h100, 0, 0, 3, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (cyc !== 4 || nreq !== 3) begin
            errors++;
            $display("FAIL cold_timing got=cyc%0d req%0d want=cyc4 req3", cyc, nreq);
        end
        checks++;
        if (mw !== 0 || mb !== 4'hF || ma !== 32'h100) begin
            errors++;
            $display("FAIL cold_memreq got=%b %h %h want=0 f 00000100", mw, mb, ma);
        end
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL cold_data got=%h want=deadbeef", rd);
        end
        exp_q.push_back(mrd(32'h100));
        access(0, 32'h103, 0, 0, 1, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (cyc !== 1 || nreq !== 0 || rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL hit_reload got=cyc%0d req%0d %h want=cyc1 req0 deadbeef",
                     cyc, nreq, rd);
        end
        checks++;
        if (hit_cnt_o !== 1 || miss_cnt_o !== 1) begin
            errors++;
            $display("FAIL cnt_cold got=%0d/%0d want=1/1", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_conflict();
        int cyc, nreq; logic [31:0] rd, ma; logic mw; logic [3:0] mb;
        exp_q.push_back(mrd(32'h200));
        access(0, 32'h200, 0, 0, 2, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (nreq !== 2 || ma !== 32'h200 || rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL conflict_200 got=req%0d %h %h want=req2 200 12345678",
                     nreq, ma, rd);
        end
        exp_q.push_back(mrd(32'h100));
        access(0, 32'h100, 0, 0, 1, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (nreq !== 1 || rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL conflict_100 got=req%0d %h want=req1 deadbeef", nreq, rd);
        end
        checks++;
        if (miss_cnt_o !== 3 || hit_cnt_o !== 1) begin
            errors++;
            $display("FAIL cnt_conflict got=%0d/%0d want=1/3", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_store_hit();
        int cyc, nreq; logic [31:0] rd, ma; logic mw; logic [3:0] mb;
        access(1, 32'h100, 32'h0000_00AA, 4'b0001, 2, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (nreq !== 2 || mw !== 1 || mb !== 4'b0001 || ma !== 32'h100) begin
            errors++;
            $display("FAIL store_hit_mem got=req%0d %b %b %h want=req2 1 0001 100",
                     nreq, mw, mb, ma);
        end
        exp_q.push_back(32'hDEAD_BEAA);
        access(0, 32'h100, 0, 0, 1, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (nreq !== 0 || rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL store_merge got=req%0d %h want=req0 deadbeaa", nreq, rd);
        end
        checks++;
        if (hit_cnt_o !== 2 || miss_cnt_o !== 3) begin
            errors++;
            $display("FAIL cnt_store got=%0d/%0d want=2/3", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_store_miss();
        int cyc, nreq; logic [31:0] rd, ma; logic mw; logic [3:0] mb;
        access(1, 32'h400, 32'h1122_3344, 4'b1111, 1, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (nreq !== 1 || mw !== 1 || mb !== 4'b1111) begin
            errors++;
            $display("FAIL store_miss_mem got=req%0d %b %b want=req1 1 1111", nreq, mw, mb);
        end
        exp_q.push_back(32'h1122_3344);
        access(0, 32'h400, 0, 0, 2, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (nreq !== 2 || rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL no_allocate got=req%0d %h want=req2 11223344", nreq, rd);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, nreq; logic [31:0] rd, ma; logic mw; logic [3:0] mb;
        access(1, 32'h400, 32'h5566_0000, 4'b1100, 1, 0, cyc, nreq, rd, mw, mb, ma);
        exp_q.push_back(32'h5566_3344);
        access(0, 32'h400, 0, 0, 1, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (cyc !== 1 || nreq !== 0 || rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL b2b_merge got=cyc%0d req%0d %h want=cyc1 req0 55663344",
                     cyc, nreq, rd);
        end
    endtask

    task automatic test_invalidate();
        int cyc, nreq; logic [31:0] rd, ma; logic mw; logic [3:0] mb;
        access(0, 32'h100, 0, 0, 1, 0, cyc, nreq, rd, mw, mb, ma);
        inv_i = 1'b1;
        @(posedge clk); #1;
        inv_i = 1'b0;
        exp_q.push_back(mrd(32'h100));
        access(0, 32'h100, 0, 0, 1, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (nreq !== 1 || rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL inv_miss got=req%0d %h want=req1 deadbeaa", nreq, rd);
        end
        exp_q.push_back(mrd(32'h200));
        access(0, 32'h200, 0, 0, 2, 1, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL inv_fill_data got=%h want=12345678", rd);
        end
        exp_q.push_back(mrd(32'h200));
        access(0, 32'h200, 0, 0, 1, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (nreq !== 1 || rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL inv_wins got=req%0d %h want=req1 12345678", nreq, rd);
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc, nreq; logic [31:0] rd, ma; logic mw; logic [3:0] mb;
        cpu_req_i = 1'b1; cpu_wr_en_i = 1'b0; cpu_addr_i = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1; cpu_req_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 0 || cpu_stall_o !== 0) begin
            errors++;
            $display("FAIL rst_mid_ctl got=%b%b want=00", mem_req_o, cpu_stall_o);
        end
        checks++;
        if (hit_cnt_o !== 0 || miss_cnt_o !== 0) begin
            errors++;
            $display("FAIL rst_mid_cnt got=%0d/%0d want=0/0", hit_cnt_o, miss_cnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(mrd(32'h100));
        access(0, 32'h100, 0, 0, 1, 0, cyc, nreq, rd, mw, mb, ma);
        checks++;
        if (nreq !== 1 || rd !== exp_q.pop_front() || miss_cnt_o !== 1) begin
            errors++;
            $display("FAIL rst_mid_line got=req%0d %h miss%0d want=req1 deadbeaa miss1",
                     nreq, rd, miss_cnt_o);
        end
    endtask

    initial begin
        mem_model[30'h40]  = 32'hDEAD_BEEF;
        mem_model[30'h80]  = 32'h1234_5678;
        test_reset();
        test_cold_load();
        test_conflict();
        test_store_hit();
        test_store_miss();
        test_back_to_back();
        test_invalidate();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
